// File: rtl/dn_ram_arbiter.sv
// Shares one single-port RAM between the CPU and the ioctl download stream via a one-byte holding buffer.
// Optional feature: define DN_CHECKSUM_EN to build the download checksum on dn_sum.
module dn_ram_arbiter #(
  parameter int AW     = 17,
  parameter int INDEX  = 0,
  parameter int STARVE = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic [7:0]    ioctl_index,
  output logic          ioctl_wait,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_wait,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout,
  output logic          dn_active,
  output logic          dn_done,
  output logic          dn_ovf,
  output logic [7:0]    dn_sum
);

  typedef enum logic [1:0] {IDLE, PEND, FORCE, DRAIN} state_t;

  localparam logic [3:0] STARVE_C = 4'(STARVE);
  localparam logic [7:0] INDEX_C  = 8'(INDEX);

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic            full;
  logic [AW-1:0]   buf_addr;
  logic [7:0]      buf_data;
  logic            index_hit, match, capture, dl_write, cpu_grant;

  assign index_hit = (ioctl_index == INDEX_C);
  assign match     = ioctl_download & ioctl_wr & index_hit & ((ioctl_addr >> AW) == 25'd0);
  assign capture   = match & ~full;
  assign ioctl_wait = full;
  assign cpu_dout  = ram_dout;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    dl_write  = 1'b0;
    cpu_grant = 1'b0;
    cpu_wait  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    case (state)
      IDLE: begin
        cpu_grant = cpu_req;
        if (capture) state_n = PEND;
      end
      PEND, DRAIN: begin
        if (!cpu_req) begin
          dl_write = 1'b1;
        end else begin
          cpu_grant = 1'b1;
          cnt_n     = cnt + 4'd1;
          if (cnt_n == STARVE_C) state_n = FORCE;
          else if (!ioctl_download) state_n = DRAIN;
        end
      end
      FORCE: begin
        dl_write = 1'b1;
        cpu_wait = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // A download write empties the buffer and restarts the starvation count.
    if (dl_write) begin
      state_n  = IDLE;
      cnt_n    = '0;
      ram_we   = 1'b1;
      ram_addr = buf_addr;
      ram_din  = buf_data;
    end else if (cpu_grant) begin
      ram_we   = cpu_we;
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      full      <= 1'b0;
      dn_active <= 1'b0;
      dn_done   <= 1'b0;
      dn_ovf    <= 1'b0;
    end else begin
      dn_done <= 1'b0;
      if (capture) full <= 1'b1;
      else if (dl_write) full <= 1'b0;
      if (match && full) dn_ovf <= 1'b1;
      if (ioctl_download && index_hit) begin
        dn_active <= 1'b1;
      end else if (dn_active && !ioctl_download && !full) begin
        dn_active <= 1'b0;
        dn_done   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (capture) begin
      buf_addr <= ioctl_addr[AW-1:0];
      buf_data <= ioctl_dout;
    end
  end

`ifdef DN_CHECKSUM_EN
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dn_sum <= '0;
    end else if (ioctl_download && index_hit && !dn_active) begin
      dn_sum <= '0;
    end else if (dl_write) begin
      dn_sum <= sum8(dn_sum, buf_data);
    end
  end
`else
  assign dn_sum = '0;
`endif

endmodule

// File: tb/tb_dn_ram_arbiter.sv
// Directed bench for dn_ram_arbiter (AW=17, INDEX=0, STARVE=4); inputs change 1 ns after each rising edge.
module tb_dn_ram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index;
  logic        ioctl_wait;
  logic        cpu_req, cpu_we;
  logic [16:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_wait;
  logic [16:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic        dn_active, dn_done, dn_ovf;
  logic [7:0]  dn_sum;

  int tests = 0;
  int fails = 0;

`ifdef DN_CHECKSUM_EN
  localparam logic [7:0] SUM_A = 8'h76;
  localparam logic [7:0] SUM_B = 8'h11;
`else
  localparam logic [7:0] SUM_A = 8'h00;
  localparam logic [7:0] SUM_B = 8'h00;
`endif

  dn_ram_arbiter #(.AW(17), .INDEX(0), .STARVE(4)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .dn_active(dn_active), .dn_done(dn_done), .dn_ovf(dn_ovf), .dn_sum(dn_sum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
  endtask

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_dout = '0; ioctl_index = '0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_din = '0; ram_dout = '0;
    tick(); tick();
    #1;
    chk("rst_ioctl_wait", ioctl_wait, 0);
    chk("rst_cpu_wait", cpu_wait, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_dn_active", dn_active, 0);
    chk("rst_dn_done", dn_done, 0);
    chk("rst_dn_ovf", dn_ovf, 0);
    chk("rst_dn_sum", dn_sum, 0);
    reset = 1'b0;

    // Single byte with idle CPU.
    tick();
    ioctl_download = 1'b1; strobe(25'h10, 8'hA5);
    #1;
    chk("t1_cap_wait", ioctl_wait, 0);
    chk("t1_cap_we", ram_we, 0);
    tick(); ioctl_wr = 1'b0; #1;
    chk("t1_wr_we", ram_we, 1);
    chk("t1_wr_addr", ram_addr, 17'h10);
    chk("t1_wr_din", ram_din, 8'hA5);
    chk("t1_wr_wait", ioctl_wait, 1);
    chk("t1_active", dn_active, 1);
    tick(); #1;
    chk("t1_after_wait", ioctl_wait, 0);
    chk("t1_after_we", ram_we, 0);

    // Overflow: second strobe while the buffer is full.
    tick(); strobe(25'h20, 8'h11); #1;
    tick(); strobe(25'h30, 8'h22); #1;
    chk("ovf_wr_addr", ram_addr, 17'h20);
    chk("ovf_wr_din", ram_din, 8'h11);
    tick(); ioctl_wr = 1'b0; #1;
    chk("ovf_flag", dn_ovf, 1);
    chk("ovf_no_wait", ioctl_wait, 0);
    chk("ovf_no_we", ram_we, 0);

    // Non-matching index and out-of-range address.
    tick(); ioctl_index = 8'd1; strobe(25'h40, 8'h33); #1;
    tick(); ioctl_wr = 1'b0; ioctl_index = 8'd0; #1;
    chk("idx_wait", ioctl_wait, 0);
    chk("idx_we", ram_we, 0);
    tick(); strobe(25'h20000, 8'h44); #1;
    tick(); ioctl_wr = 1'b0; #1;
    chk("oor_wait", ioctl_wait, 0);
    chk("oor_we", ram_we, 0);

    // Starvation with the CPU requesting every cycle.
    tick(); strobe(25'h40, 8'h5A); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h100; #1;
    chk("st_cap_addr", ram_addr, 17'h100);
    tick(); ioctl_wr = 1'b0; cpu_we = 1'b1; cpu_addr = 17'h123; cpu_din = 8'h77; #1;
    for (int i = 0; i < 4; i++) begin
      chk("st_cpu_addr", ram_addr, 17'h123);
      chk("st_cpu_we", ram_we, 1);
      chk("st_cpu_nowait", cpu_wait, 0);
      chk("st_iowait", ioctl_wait, 1);
      tick(); #1;
    end
    chk("st_force_wait", cpu_wait, 1);
    chk("st_force_we", ram_we, 1);
    chk("st_force_addr", ram_addr, 17'h40);
    chk("st_force_din", ram_din, 8'h5A);
    tick(); #1;
    chk("st_held_addr", ram_addr, 17'h123);
    chk("st_held_din", ram_din, 8'h77);
    chk("st_held_we", ram_we, 1);
    chk("st_held_nowait", cpu_wait, 0);
    chk("st_iowait_low", ioctl_wait, 0);
    cpu_we = 1'b0; ram_dout = 8'h3C; #1;
    chk("cpu_dout", cpu_dout, 8'h3C);

    // Download ends with a byte pending; drained by the force rule.
    tick(); strobe(25'h50, 8'h66); cpu_addr = 17'h200; #1;
    tick(); ioctl_wr = 1'b0; ioctl_download = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("dr_cpu_we", ram_we, 0);
      chk("dr_active", dn_active, 1);
      tick(); #1;
    end
    chk("dr_force_wait", cpu_wait, 1);
    chk("dr_force_addr", ram_addr, 17'h50);
    chk("dr_force_din", ram_din, 8'h66);
    tick(); #1;
    chk("dr_pre_done", dn_done, 0);
    chk("dr_pre_active", dn_active, 1);
    tick(); #1;
    chk("dr_done", dn_done, 1);
    chk("dr_inactive", dn_active, 0);
    chk("dr_sum", dn_sum, SUM_A);
    tick(); #1;
    chk("dr_done_once", dn_done, 0);
    cpu_req = 1'b0;

    // Checksum over a fresh download.
    tick(); ioctl_download = 1'b1; strobe(25'h0, 8'hFF); #1;
    tick(); ioctl_wr = 1'b0; #1;
    chk("cs_wr0", ram_din, 8'hFF);
    tick(); strobe(25'h1, 8'h02); #1;
    tick(); ioctl_wr = 1'b0; #1;
    tick(); strobe(25'h2, 8'h10); #1;
    tick(); ioctl_wr = 1'b0; ioctl_download = 1'b0; #1;
    chk("cs_wr2", ram_din, 8'h10);
    tick(); #1;
    tick(); #1;
    chk("cs_done", dn_done, 1);
    tick(); #1;
    chk("cs_sum", dn_sum, SUM_B);

    // Reset mid-download discards the pending byte.
    tick(); ioctl_download = 1'b1; strobe(25'h3, 8'h99); cpu_req = 1'b1; #1;
    tick(); ioctl_wr = 1'b0; #1;
    chk("rm_pending", ioctl_wait, 1);
    chk("rm_ovf_sticky", dn_ovf, 1);
    reset = 1'b1; cpu_req = 1'b0; ioctl_download = 1'b0; #1;
    chk("rm_wait", ioctl_wait, 0);
    chk("rm_we", ram_we, 0);
    chk("rm_ovf", dn_ovf, 0);
    chk("rm_sum", dn_sum, 0);
    chk("rm_active", dn_active, 0);
    tick(); reset = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("rm_no_write", ram_we, 0);
      tick(); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dn_ram_arbiter.md
# dn_ram_arbiter

Shares one single-port synchronous RAM between the CPU and the ioctl download stream. Download bytes for one configured `ioctl_index` are captured into a one-byte holding register, throttled back to the HPS with `ioctl_wait`, and written into idle RAM cycles. A bounded-starvation rule lets the download steal the port from the CPU. The block sits between the emu-level ioctl signals and the `system` RAM instances, and replaces direct `dn_wr` wiring for any RAM that the CPU can also write.

## Interface
Parameters:
- `AW`, 17: RAM address width; download bytes with `ioctl_addr >= 2**AW` are dropped.
- `INDEX`, 0: `ioctl_index` value served by this instance.
- `STARVE`, 4: number of consecutive CPU-granted cycles with a byte pending before the download forces the port (1..15).

Ports:
- `clk_sys` in 1: system clock; all logic runs on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `ioctl_download`, `ioctl_wr` in 1: download-active level and write strobe.
- `ioctl_addr` in 25, `ioctl_dout` in 8, `ioctl_index` in 8: download address, data and index.
- `ioctl_wait` out 1: registered; high while the holding register is full.
- `cpu_req`, `cpu_we` in 1: CPU access request this cycle; write enable.
- `cpu_addr` in AW, `cpu_din` in 8: CPU address and write data.
- `cpu_dout` out 8: RAM read data, valid one cycle after a granted read.
- `cpu_wait` out 1: combinational; high on a forced cycle, where the CPU must hold its request.
- `ram_addr` out AW, `ram_din` out 8, `ram_we` out 1: RAM port.
- `ram_dout` in 8: RAM read data.
- `dn_active` out 1: a matching download is in progress; use it as the system reset hold.
- `dn_done` out 1: one-cycle pulse when a matching download has fully drained.
- `dn_ovf` out 1: sticky flag; a write strobe arrived while `ioctl_wait` was high.
- `dn_sum` out 8: download checksum (see Configuration).

## Operation
- Match: `ioctl_download & ioctl_wr & (ioctl_index==INDEX) & (ioctl_addr < 2**AW)`.
  - Match with the buffer empty: latch the address and data, set full. `ioctl_wait` goes high on the next cycle.
  - Match with the buffer full: byte discarded, `dn_ovf` set.
  - Non-matching strobes are ignored.
- FSM states:
  - IDLE: buffer empty.
  - PEND: buffer full, starvation counter counting.
  - FORCE: buffer full, counter reached STARVE.
  - DRAIN: download ended, buffer still full.
- Port grant each cycle:
  - FORCE: download wins. `cpu_wait=1`, `ram_we=1`, address and data come from the buffer.
  - PEND or DRAIN with `cpu_req=0`: download write issues.
  - Otherwise, if `cpu_req=1`: the CPU drives `ram_addr`, `ram_din=cpu_din`, `ram_we=cpu_we`. In PEND this increments the counter.
- After a download write issues: buffer clears, counter clears, next state is IDLE.
- Transitions:
  - IDLE to PEND on capture.
  - PEND to FORCE when the counter reaches STARVE.
  - PEND to DRAIN when `ioctl_download` falls with the buffer full.
  - DRAIN follows the same grant and force rules as PEND.
- `dn_active` sets when `ioctl_download=1` with `ioctl_index==INDEX`. It clears in the cycle after `ioctl_download=0` and the buffer is empty; `dn_done` pulses for that one cycle.
- `cpu_dout = ram_dout`, passed through. Its value is undefined after a download-write cycle.
- No CPU write is ever lost: a forced cycle always asserts `cpu_wait`.

## Timing
- Reset values: `ioctl_wait=0`, `cpu_wait=0`, `ram_we=0`, `ram_addr=0`, `ram_din=0`, `dn_active=0`, `dn_done=0`, `dn_ovf=0`, `dn_sum=0`. Buffer empty, counter 0, state IDLE.
- Capture to RAM write: 1 cycle minimum, STARVE+1 cycles maximum.
- Download throughput: at most 1 byte per 2 cycles.
- `ioctl_wait` rises one cycle after capture and falls in the cycle after the write.
- A strobe in the same cycle the buffer drains is still rejected, because `ioctl_wait` is registered.
- Reset mid-download: the pending byte is discarded and no RAM write occurs.

## Configuration
- `DN_CHECKSUM_EN` defined: `dn_sum` is the modulo-256 sum of every byte actually written to RAM by the download. It clears on the rising edge of `dn_active` and holds its value after `dn_done`.
- `DN_CHECKSUM_EN` not defined: `dn_sum` is tied to 0 and the adder is not built. The port exists in both cases.

## Test plan
- Idle CPU, INDEX=0, strobe writing 0xA5 at address 0x00010: `ram_we` high with addr 0x00010 and data 0xA5 one cycle later; `ioctl_wait` high for exactly 1 cycle.
- `cpu_req` held high, STARVE=4, one byte captured: CPU granted for 4 cycles, then 1 forced cycle with `cpu_wait=1` and the download write; a CPU write held across the forced cycle lands on the next cycle.
- Second strobe issued while `ioctl_wait=1`: byte not written, `dn_ovf=1`, and it stays set until reset.
- Strobes with `ioctl_index=1`, and with `ioctl_addr=0x20000` when AW=17: no RAM write, `ioctl_wait` stays 0.
- `ioctl_download` falls with a byte pending and `cpu_req=1`: state goes DRAIN, the byte is written by the force rule, then `dn_done` pulses once and `dn_active` goes 0.
- With `DN_CHECKSUM_EN`, bytes 0xFF, 0x02, 0x10: `dn_sum=0x11` after `dn_done`; reset asserted mid-download clears `dn_sum` and the pending byte.
